// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the
// valid/ready instruction port toward the decoder and the branch redirect input.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] redirect_target;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, funct, pc, pc_plus4,
      input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, funct, pc, pc_plus4,
      output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, fetches one word per req/ack
// transaction and holds it for the decoder under valid/ready flow control.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] target;

   assign target = bus.redirect_target & 32'hFFFF_FFFC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         instr_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      instr_d    = instr_q;
      unique case (state_q)
         IDLE: begin
            state_d    = FETCH;
            req_addr_d = bus.redirect ? target : pc_q;
            if (bus.redirect) pc_d = target;
         end
         FETCH: begin
            // Redirect squashes the word; without an ack the request must still be drained.
            if (bus.redirect) begin
               pc_d    = target;
               state_d = bus.imem_ack ? IDLE : DRAIN;
            end else if (bus.imem_ack) begin
               instr_d = bus.imem_rdata;
               state_d = HOLD;
            end
         end
         DRAIN: begin
            if (bus.redirect) pc_d = target;
            if (bus.imem_ack) state_d = IDLE;
         end
         HOLD: begin
            if (bus.redirect) begin
               pc_d    = target;
               state_d = IDLE;
            end else if (bus.instr_ready) begin
               pc_d    = req_addr_q + 32'd4;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
      bus.imem_addr   = req_addr_q;
      bus.instr_valid = (state_q == HOLD);
      bus.instr       = instr_q;
      bus.opcode      = instr_q[31:26];
      bus.funct       = instr_q[5:0];
      bus.pc          = req_addr_q;
      bus.pc_plus4    = req_addr_q + 32'd4;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: an outstanding request (possibly squashed), a held instruction, or neither.
   bit          m_init = 0;
   bit          m_req, m_squash, m_hold;
   logic [31:0] m_pc, m_addr, m_instr;

   always @(posedge clk) begin
      logic [31:0] tgt;
      tgt = bus.redirect_target - (bus.redirect_target % 4);
      if (!rst_n) begin
         m_init = 1; m_req = 0; m_squash = 0; m_hold = 0;
         m_pc = RST_PC; m_addr = RST_PC; m_instr = 0;
      end else if (m_init) begin
         if (m_hold) begin
            if (bus.redirect) begin
               m_pc = tgt; m_hold = 0;
            end else if (bus.instr_ready) begin
               m_pc = m_addr + 4; m_hold = 0;
            end
         end else if (m_req) begin
            if (bus.redirect) m_pc = tgt;
            if (bus.imem_ack) begin
               if (!m_squash && !bus.redirect) begin
                  m_hold = 1; m_instr = bus.imem_rdata;
               end
               m_req = 0; m_squash = 0;
            end else if (bus.redirect) begin
               m_squash = 1;
            end
         end else begin
            if (bus.redirect) m_pc = tgt;
            m_addr = m_pc;
            m_req  = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
         if (m_req) check("imem_addr", bus.imem_addr, m_addr);
         check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_hold});
         check("pc", bus.pc, m_addr);
         check("pc_plus4", bus.pc_plus4, m_addr + 32'd4);
         check("instr", bus.instr, m_instr);
         check("opcode", {26'd0, bus.opcode}, {26'd0, m_instr[31:26]});
         check("funct", {26'd0, bus.funct}, {26'd0, m_instr[5:0]});
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.imem_ack = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
      bus.redirect = 0; bus.redirect_target = '0;

      // Reset and start-up
      repeat (3) begin
         step();
         check("rst_req", {31'd0, bus.imem_req}, 32'd0);
         check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
         check("rst_opcode", {26'd0, bus.opcode}, 32'd0);
         check("rst_funct", {26'd0, bus.funct}, 32'd0);
      end
      rst_n = 1'b1;
      step();
      check("start_req", {31'd0, bus.imem_req}, 32'd1);
      check("start_addr", bus.imem_addr, 32'h0040_0000);

      // Sequential fetch, zero-wait memory, ready held high
      bus.instr_ready = 1;
      bus.imem_ack = 1; bus.imem_rdata = 32'h8C08_0004;
      step();
      bus.imem_ack = 0;
      check("lw_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("lw_opcode", {26'd0, bus.opcode}, 32'b100011);
      check("lw_funct", {26'd0, bus.funct}, 32'b000100);
      check("lw_pc", bus.pc, 32'h0040_0000);
      step();
      step();
      check("seq_addr1", bus.imem_addr, 32'h0040_0004);
      bus.imem_ack = 1; bus.imem_rdata = 32'h0109_5020;
      step();
      bus.imem_ack = 0;
      check("add_opcode", {26'd0, bus.opcode}, 32'b000000);
      check("add_funct", {26'd0, bus.funct}, 32'b100000);
      check("add_pc", bus.pc, 32'h0040_0004);
      step();
      step();
      check("seq_addr2", bus.imem_addr, 32'h0040_0008);

      // Backpressure in HOLD
      bus.instr_ready = 0;
      bus.imem_ack = 1; bus.imem_rdata = 32'h2108_FFFF;
      step();
      bus.imem_ack = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
         check("bp_instr", bus.instr, 32'h2108_FFFF);
         check("bp_pc", bus.pc, 32'h0040_0008);
         check("bp_req", {31'd0, bus.imem_req}, 32'd0);
      end
      bus.instr_ready = 1;
      step();
      bus.instr_ready = 0;
      step();
      check("bp_next_addr", bus.imem_addr, 32'h0040_000C);

      // Redirect in HOLD beats ready; target misaligned
      bus.imem_ack = 1; bus.imem_rdata = 32'h1234_5678;
      step();
      bus.imem_ack = 0;
      bus.instr_ready = 1; bus.redirect = 1; bus.redirect_target = 32'h0040_0023;
      step();
      bus.instr_ready = 0; bus.redirect = 0;
      check("rd_hold_valid", {31'd0, bus.instr_valid}, 32'd0);
      step();
      check("rd_hold_addr", bus.imem_addr, 32'h0040_0020);

      // Redirect in FETCH with ack delayed
      bus.redirect = 1; bus.redirect_target = 32'h0040_0100;
      step();
      bus.redirect = 0;
      for (int i = 0; i < 2; i++) begin
         check("drain_req", {31'd0, bus.imem_req}, 32'd1);
         check("drain_addr", bus.imem_addr, 32'h0040_0020);
         step();
      end
      check("drain_addr_last", bus.imem_addr, 32'h0040_0020);
      bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
      step();
      bus.imem_ack = 0;
      check("drain_valid", {31'd0, bus.instr_valid}, 32'd0);
      step();
      check("drain_next_addr", bus.imem_addr, 32'h0040_0100);
      check("drain_next_valid", {31'd0, bus.instr_valid}, 32'd0);

      // PC wrap, then reset while a request is being acked
      bus.redirect = 1; bus.redirect_target = 32'hFFFF_FFFC;
      bus.imem_ack = 1; bus.imem_rdata = 32'hAAAA_AAAA;
      step();
      bus.redirect = 0; bus.imem_ack = 0;
      step();
      check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
      bus.imem_ack = 1; bus.imem_rdata = 32'h0000_0020;
      step();
      bus.imem_ack = 0;
      check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
      bus.instr_ready = 1;
      step();
      bus.instr_ready = 0;
      step();
      check("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
      rst_n = 0; bus.imem_ack = 1; bus.imem_rdata = 32'h5555_5555;
      step();
      check("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
      check("midrst_opcode", {26'd0, bus.opcode}, 32'd0);
      rst_n = 1;
      step();
      bus.imem_ack = 0;
      step();
      check("midrst_addr", bus.imem_addr, RST_PC);

      // Randomized traffic, including stray acks and occasional resets
      for (int i = 0; i < 4000; i++) begin
         rst_n               = ($urandom_range(0, 199) != 0);
         bus.redirect        = ($urandom_range(0, 7) == 0);
         bus.redirect_target = $urandom;
         bus.imem_ack        = ($urandom_range(0, 2) != 0);
         bus.imem_rdata      = $urandom;
         bus.instr_ready     = ($urandom_range(0, 1) == 1);
         step();
      end
      rst_n = 1; bus.redirect = 0; bus.imem_ack = 0; bus.instr_ready = 0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
